// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset core.
// Optional performance counters are built only when PERF_COUNTER_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_branch,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic             pc_src,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [2:0]        after_retire;
  logic [WAIT_W-1:0] wait_cnt;
  logic              f_load;
  logic              f_store;
  logic              f_regw;
  logic              f_branch;
  logic              timed_out;

  assign after_retire = run ? S_FETCH : S_IDLE;
  assign timed_out    = !mem_ack && (wait_cnt == WAIT_LAST);

  // Store wins over load when both flags are set, so MEM only heads to WB for a pure load.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ack)        next_state = S_DECODE;
        else if (timed_out) next_state = S_FAULT;
      end
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (f_branch)                next_state = after_retire;
        else if (f_load || f_store)  next_state = S_MEM;
        else if (f_regw)             next_state = S_WB;
        else                         next_state = after_retire;
      end
      S_MEM: begin
        if (mem_ack)        next_state = f_store ? after_retire : S_WB;
        else if (timed_out) next_state = S_FAULT;
      end
      S_WB:     next_state = after_retire;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      f_load   <= 1'b0;
      f_store  <= 1'b0;
      f_regw   <= 1'b0;
      f_branch <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state == S_FETCH || next_state == S_MEM) && next_state != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !mem_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_DECODE) begin
        f_load   <= dec_mem_read;
        f_store  <= dec_mem_write;
        f_regw   <= dec_reg_write;
        f_branch <= dec_branch;
      end
    end
  end

  // Only the ack-cycle pulses (ir_we, mdr_we, MEM pc_we) look at mem_ack directly.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    ir_we   = 1'b0;
    mdr_we  = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 1'b0;
    fault   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_EXEC: begin
        if (f_branch) begin
          pc_we  = 1'b1;
          pc_src = alu_zero;
        end else if (!(f_load || f_store || f_regw)) begin
          pc_we = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = f_store;
        pc_we   = mem_ack && f_store;
        mdr_we  = mem_ack && !f_store;
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = f_load && !f_store;
        pc_we  = 1'b1;
      end
      S_FAULT:  fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef PERF_COUNTER_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (pc_we) ret_q <= ret_q + 1'b1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-vector checks
// for each instruction class, timeout/fault, reset, and the optional counters.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_reg_write;
  logic       dec_branch;
  logic       alu_zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       mdr_we;
  logic       rf_we;
  logic       wb_sel;
  logic       pc_we;
  logic       pc_src;
  logic       fault;
  logic [2:0] state_o;
  logic [3:0] cycle_cnt;
  logic [3:0] instret_cnt;
  logic [9:0] ctl;

  int total = 0;
  int bad   = 0;

  // Control vector order: mem_req mem_we iord ir_we mdr_we rf_we wb_sel pc_we pc_src fault
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_FREQ  = 10'b1000000000;
  localparam logic [9:0] C_FACK  = 10'b1001000000;
  localparam logic [9:0] C_LDM   = 10'b1010000000;
  localparam logic [9:0] C_LDACK = 10'b1010100000;
  localparam logic [9:0] C_STM   = 10'b1110000000;
  localparam logic [9:0] C_STACK = 10'b1110000100;
  localparam logic [9:0] C_WBALU = 10'b0000010100;
  localparam logic [9:0] C_WBLD  = 10'b0000011100;
  localparam logic [9:0] C_BRT   = 10'b0000000110;
  localparam logic [9:0] C_NXT   = 10'b0000000100;
  localparam logic [9:0] C_FLT   = 10'b0000000001;

  // Decoder flag order: mem_read mem_write reg_write branch
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_ALU  = 4'b0010;
  localparam logic [3:0] F_LW   = 4'b1010;
  localparam logic [3:0] F_SW   = 4'b0100;
  localparam logic [3:0] F_BEQ  = 4'b0001;
  localparam logic [3:0] F_BOTH = 4'b1110;

  typedef struct packed {
    logic       run;
    logic       ack;
    logic       zero;
    logic [3:0] flags;
    logic [2:0] st;
    logic [9:0] ctl;
  } row_t;

  assign ctl = {mem_req, mem_we, iord, ir_we, mdr_we, rf_we, wb_sel, pc_we, pc_src, fault};

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_branch(dec_branch),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_src(pc_src), .fault(fault), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic r, input logic a, input logic z,
                              input logic [3:0] f, input logic [2:0] s, input logic [9:0] c);
    row_t x;
    x.run = r; x.ack = a; x.zero = z; x.flags = f; x.st = s; x.ctl = c;
    return x;
  endfunction

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0;
    {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = F_NONE;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state_o); end
    total++;
    if (ctl !== C_NONE) begin bad++; $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
    total++;
    if ({cycle_cnt, instret_cnt} !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_counters got=%h exp=00", {cycle_cnt, instret_cnt});
    end
    reset = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ctl !== C_FREQ || state_o !== 3'd1) begin
      bad++; $display("[TB] FAIL reset_enter_fetch got=%0d/%b exp=1/%b", state_o, ctl, C_FREQ);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ctl !== C_NONE || state_o !== 3'd0) begin
      bad++; $display("[TB] FAIL reset_mid_fetch got=%0d/%b exp=0/%b", state_o, ctl, C_NONE);
    end
    reset = 1'b0; run = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_ALU,  3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_ALU,  3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_ALU,  3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_NONE, 3'd3, C_NONE));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_NONE, 3'd5, C_WBALU));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_NONE, 3'd0, C_NONE));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL addi_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL addi_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_delayed_ack;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_LW, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd3, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd4, C_LDM));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd4, C_LDM));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_LW, 3'd4, C_LDM));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_LW, 3'd4, C_LDACK));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_LW, 3'd5, C_WBLD));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_LW, 3'd0, C_NONE));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL lw_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL lw_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_BEQ, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_BEQ, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_BEQ, 3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b1, F_BEQ, 3'd3, C_BRT));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_BEQ, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_BEQ, 3'd2, C_NONE));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_BEQ, 3'd3, C_NXT));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_BEQ, 3'd0, C_NONE));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL beq_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL beq_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_run_drop;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_SW, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd3, C_NONE));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_SW, 3'd4, C_STM));
    rows.push_back(mk(1'b0, 1'b1, 1'b0, F_SW, 3'd4, C_STACK));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_SW, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd1, C_FREQ));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_SW, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_SW, 3'd2, C_NONE));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_SW, 3'd3, C_NONE));
    rows.push_back(mk(1'b0, 1'b1, 1'b0, F_SW, 3'd4, C_STACK));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_SW, 3'd0, C_NONE));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL sw_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL sw_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_opcode_corners;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_NONE, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd3, C_NXT));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_BOTH, 3'd1, C_FACK));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_BOTH, 3'd2, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_BOTH, 3'd3, C_NONE));
    rows.push_back(mk(1'b0, 1'b1, 1'b0, F_BOTH, 3'd4, C_STACK));
    rows.push_back(mk(1'b0, 1'b0, 1'b0, F_BOTH, 3'd0, C_NONE));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL corner_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL corner_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    row_t rows[$];
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd0, C_NONE));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd1, C_FREQ));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd1, C_FREQ));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd1, C_FREQ));
    rows.push_back(mk(1'b1, 1'b0, 1'b0, F_NONE, 3'd1, C_FREQ));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_NONE, 3'd7, C_FLT));
    rows.push_back(mk(1'b1, 1'b1, 1'b0, F_NONE, 3'd7, C_FLT));
    foreach (rows[i]) begin
      run = rows[i].run; mem_ack = rows[i].ack; alu_zero = rows[i].zero;
      {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = rows[i].flags;
      #1;
      total++;
      if (state_o !== rows[i].st) begin bad++; $display("[TB] FAIL timeout_state[%0d] got=%0d exp=%0d", i, state_o, rows[i].st); end
      total++;
      if (ctl !== rows[i].ctl) begin bad++; $display("[TB] FAIL timeout_ctl[%0d] got=%b exp=%b", i, ctl, rows[i].ctl); end
      @(posedge clk); #1;
    end
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ctl !== C_NONE || state_o !== 3'd0) begin
      bad++; $display("[TB] FAIL fault_clear got=%0d/%b exp=0/%b", state_o, ctl, C_NONE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_counters;
    logic [3:0] exp_cyc;
    logic [3:0] exp_ret;
    reset = 1'b1; run = 1'b1; mem_ack = 1'b1; alu_zero = 1'b0;
    {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch} = F_NONE;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int e = 1; e <= 49; e++) begin
      @(posedge clk); #1;
      if (e == 46 || e == 49) begin
`ifdef PERF_COUNTER_EN
        exp_cyc = (e == 46) ? 4'd14 : 4'd1;
        exp_ret = (e == 46) ? 4'd15 : 4'd0;
`else
        exp_cyc = 4'd0;
        exp_ret = 4'd0;
`endif
        total++;
        if (cycle_cnt !== exp_cyc) begin bad++; $display("[TB] FAIL cycle_cnt@%0d got=%0d exp=%0d", e, cycle_cnt, exp_cyc); end
        total++;
        if (instret_cnt !== exp_ret) begin bad++; $display("[TB] FAIL instret_cnt@%0d got=%0d exp=%0d", e, instret_cnt, exp_ret); end
      end
    end
    total++;
    if (state_o !== 3'd1) begin bad++; $display("[TB] FAIL cnt_in_fetch got=%0d exp=1", state_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({state_o, cycle_cnt, instret_cnt} !== 11'd0) begin
      bad++; $display("[TB] FAIL cnt_reset got=%0d/%0d/%0d exp=0/0/0", state_o, cycle_cnt, instret_cnt);
    end
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_delayed_ack();
    test_back_to_back();
    test_store_run_drop();
    test_opcode_corners();
    test_timeout();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
